// File: rtl/accel_pkg.sv
// Shared constants for the accelerator: memory geometry, loader header layout,
// packet type codes and the loader state encoding.
package accel_pkg;

    localparam int NUM_SIZE         = 16;
    localparam int NUM_INSTRUCTIONS = 16;
    localparam int WORDS_IN_MEMORY  = 32;

    // Header word layout: [31:28] type, [27:20] count, [19:15] base
    localparam int HDR_TYPE_HI  = 31;
    localparam int HDR_TYPE_LO  = 28;
    localparam int HDR_COUNT_HI = 27;
    localparam int HDR_COUNT_LO = 20;
    localparam int HDR_BASE_HI  = 19;
    localparam int HDR_BASE_LO  = 15;

    localparam logic [3:0] TYPE_INSTR = 4'd1;
    localparam logic [3:0] TYPE_DATA  = 4'd2;
    localparam logic [3:0] TYPE_START = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INSTR   = 3'd1,
        ST_DATA_LO = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: accepts a valid/ready stream of header + payload packets and
// writes them into the instruction store and data memory, then releases the
// accelerator core with run. Protocol violations park the block in ERR.
module prog_loader #(
    parameter int NUM_SIZE         = accel_pkg::NUM_SIZE,
    parameter int NUM_INSTRUCTIONS = accel_pkg::NUM_INSTRUCTIONS,
    parameter int WORDS_IN_MEMORY  = accel_pkg::WORDS_IN_MEMORY
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [31:0]                         in_data,
    input  logic                                in_last,
    output logic                                instr_we,
    output logic [$clog2(NUM_INSTRUCTIONS)-1:0] instr_addr,
    output logic [31:0]                         instr_wdata,
    output logic                                mem_we,
    output logic [$clog2(WORDS_IN_MEMORY)-1:0]  mem_addr,
    output logic [NUM_SIZE-1:0]                 mem_wdata,
    output logic                                run,
    output logic                                err
);
    import accel_pkg::*;

    localparam int IAW = $clog2(NUM_INSTRUCTIONS);
    localparam int MAW = $clog2(WORDS_IN_MEMORY);

    state_e          state_q, state_d;
    logic            ready_en_q;
    logic [8:0]      addr_q, addr_d;
    logic [7:0]      rem_q, rem_d;
    logic [15:0]     hi_q, hi_d;

    logic            instr_we_q, instr_we_d;
    logic [IAW-1:0]  instr_addr_q, instr_addr_d;
    logic [31:0]     instr_wdata_q, instr_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic [MAW-1:0]  mem_addr_q, mem_addr_d;
    logic [NUM_SIZE-1:0] mem_wdata_q, mem_wdata_d;

    logic            accept;
    logic [3:0]      hdr_type;
    logic [7:0]      hdr_count;
    logic [4:0]      hdr_base;
    logic [8:0]      hdr_span;
    logic            instr_fits;
    logic            mem_fits;

    assign accept    = in_valid && in_ready;
    assign hdr_type  = in_data[HDR_TYPE_HI:HDR_TYPE_LO];
    assign hdr_count = in_data[HDR_COUNT_HI:HDR_COUNT_LO];
    assign hdr_base  = in_data[HDR_BASE_HI:HDR_BASE_LO];
    // 9-bit sum so base+count never wraps before the depth comparison
    assign hdr_span   = {4'd0, hdr_base} + {1'b0, hdr_count};
    assign instr_fits = {23'd0, hdr_span} <= 32'(NUM_INSTRUCTIONS);
    assign mem_fits   = {23'd0, hdr_span} <= 32'(WORDS_IN_MEMORY);

    // State register; ready_en_q keeps in_ready low until the first edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state and write-port computation; every accepted payload word is written
    // even when its in_last flag is wrong (the error is taken after the write)
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        hi_d          = hi_q;
        instr_we_d    = 1'b0;
        instr_addr_d  = instr_addr_q;
        instr_wdata_d = instr_wdata_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = {4'd0, hdr_base};
                    rem_d  = hdr_count;
                    case (hdr_type)
                        TYPE_INSTR: begin
                            if (!instr_fits)             state_d = ST_ERR;
                            else if (hdr_count == 8'd0)  state_d = in_last ? ST_IDLE : ST_ERR;
                            else                         state_d = in_last ? ST_ERR : ST_INSTR;
                        end
                        TYPE_DATA: begin
                            if (!mem_fits)               state_d = ST_ERR;
                            else if (hdr_count == 8'd0)  state_d = in_last ? ST_IDLE : ST_ERR;
                            else                         state_d = in_last ? ST_ERR : ST_DATA_LO;
                        end
                        TYPE_START: state_d = in_last ? ST_RUN : ST_ERR;
                        default:    state_d = ST_ERR;
                    endcase
                end
            end
            ST_INSTR: begin
                if (accept) begin
                    instr_we_d    = 1'b1;
                    instr_addr_d  = addr_q[IAW-1:0];
                    instr_wdata_d = in_data;
                    addr_d        = addr_q + 9'd1;
                    rem_d         = rem_q - 8'd1;
                    if (in_last != (rem_q == 8'd1)) state_d = ST_ERR;
                    else if (rem_q == 8'd1)         state_d = ST_IDLE;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[MAW-1:0];
                    mem_wdata_d = NUM_SIZE'(in_data[15:0]);
                    hi_d        = in_data[31:16];
                    addr_d      = addr_q + 9'd1;
                    rem_d       = rem_q - 8'd1;
                    // The final word carries the last one or two values
                    if (in_last != (rem_q <= 8'd2)) state_d = ST_ERR;
                    else if (rem_q >= 8'd2)         state_d = ST_DATA_HI;
                    else                            state_d = ST_IDLE;
                end
            end
            ST_DATA_HI: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q[MAW-1:0];
                mem_wdata_d = NUM_SIZE'(hi_q);
                addr_d      = addr_q + 9'd1;
                rem_d       = rem_q - 8'd1;
                state_d     = (rem_q == 8'd1) ? ST_IDLE : ST_DATA_LO;
            end
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready = 1'b0;
        run      = 1'b0;
        err      = 1'b0;
        case (state_q)
            ST_IDLE, ST_INSTR, ST_DATA_LO: in_ready = ready_en_q;
            ST_RUN:  run = 1'b1;
            ST_ERR:  err = 1'b1;
            default: ;
        endcase
    end

    // Packet bookkeeping and registered write ports (one-cycle write latency)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q        <= '0;
            rem_q         <= '0;
            hi_q          <= '0;
            instr_we_q    <= 1'b0;
            instr_addr_q  <= '0;
            instr_wdata_q <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            hi_q          <= hi_d;
            instr_we_q    <= instr_we_d;
            instr_addr_q  <= instr_addr_d;
            instr_wdata_q <= instr_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign instr_we    = instr_we_q;
    assign instr_addr  = instr_addr_q;
    assign instr_wdata = instr_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios and randomized packets compared
// against a word-level reference model of the loader protocol.
module tb_prog_loader;

    localparam int IAW    = 4;
    localparam int MAW    = 5;
    localparam int F_IDLE = 0;
    localparam int F_RUN  = 1;
    localparam int F_ERR  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic [31:0]    in_data = 32'd0;
    logic           in_ready;
    logic           instr_we;
    logic [IAW-1:0] instr_addr;
    logic [31:0]    instr_wdata;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [15:0]    mem_wdata;
    logic           run;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;
    int both_hi  = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t act_instr[$];
    wr_t act_mem[$];
    wr_t exp_instr[$];
    wr_t exp_mem[$];
    wr_t mon_w;

    logic [31:0] pkt_data[0:40];
    logic        pkt_last[0:40];

    prog_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .instr_we(instr_we), .instr_addr(instr_addr), .instr_wdata(instr_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .run(run), .err(err)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (instr_we) begin
            mon_w.addr = int'(instr_addr);
            mon_w.data = instr_wdata;
            act_instr.push_back(mon_w);
        end
        if (mem_we) begin
            mon_w.addr = int'(mem_addr);
            mon_w.data = {16'd0, mem_wdata};
            act_mem.push_back(mon_w);
        end
        if (instr_we && mem_we) both_hi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one word and hold it until accepted; called and returns on a negedge
    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Reference model: expected writes and final status of one packet
    task automatic model_packet(input int nw, output int n_acc, output int fin);
        logic [31:0] hdr;
        logic [31:0] w;
        int typ, cnt, base, depth, nwords;
        wr_t e;
        exp_instr.delete();
        exp_mem.delete();
        hdr   = pkt_data[0];
        typ   = int'(hdr[31:28]);
        cnt   = int'(hdr[27:20]);
        base  = int'(hdr[19:15]);
        n_acc = 1;
        fin   = F_IDLE;
        if (typ == 3) begin
            fin = pkt_last[0] ? F_RUN : F_ERR;
            return;
        end
        if (typ != 1 && typ != 2) begin
            fin = F_ERR;
            return;
        end
        depth = (typ == 1) ? 16 : 32;
        if (base + cnt > depth) begin fin = F_ERR; return; end
        if (cnt == 0) begin fin = pkt_last[0] ? F_IDLE : F_ERR; return; end
        if (pkt_last[0]) begin fin = F_ERR; return; end
        nwords = (typ == 1) ? cnt : (cnt + 1) / 2;
        for (int i = 0; i < nwords && i + 1 < nw; i++) begin
            w = pkt_data[i + 1];
            n_acc++;
            if (typ == 1) begin
                e.addr = base + i; e.data = w; exp_instr.push_back(e);
            end else begin
                e.addr = base + 2 * i; e.data = {16'd0, w[15:0]}; exp_mem.push_back(e);
            end
            if (pkt_last[i + 1] != (i == nwords - 1)) begin fin = F_ERR; return; end
            if (typ == 2 && 2 * i + 1 < cnt) begin
                e.addr = base + 2 * i + 1; e.data = {16'd0, w[31:16]}; exp_mem.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, instr_we, instr_addr, instr_wdata, mem_we, mem_addr, mem_wdata, run, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b iwe=%b ia=%h id=%h mwe=%b ma=%h md=%h run=%b err=%b, expected all 0",
                     in_ready, instr_we, instr_addr, instr_wdata, mem_we, mem_addr, mem_wdata, run, err);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: in_ready=%b, expected 0", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || err !== 1'b0 || run !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_edge: rdy=%b err=%b run=%b, expected 1 0 0", in_ready, err, run);
        end
    endtask

    task automatic test_instr();
        logic [31:0] d;
        send_word(32'h1031_0000, 1'b0);
        n_checks++;
        if (instr_we !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL instr_hdr_nowrite: iwe=%b mwe=%b, expected 0 0", instr_we, mem_we);
        end
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            send_word(d, (i == 2));
            n_checks++;
            if (instr_we !== 1'b1 || instr_addr !== 4'(2 + i) || instr_wdata !== d) begin
                n_fail++;
                $display("FAIL instr_wr%0d: we=%b addr=%0d data=%h, expected 1 %0d %h",
                         i, instr_we, instr_addr, instr_wdata, 2 + i, d);
            end
        end
        @(negedge clk);
        n_checks++;
        if (instr_we !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL instr_done: iwe=%b err=%b rdy=%b, expected 0 0 1", instr_we, err, in_ready);
        end
    endtask

    task automatic test_data();
        send_word(32'h2034_0000, 1'b0);
        send_word(32'h0002_0001, 1'b0);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 5'd8 || mem_wdata !== 16'd1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL data_lo0: we=%b addr=%0d data=%h rdy=%b, expected 1 8 0001 0", mem_we, mem_addr, mem_wdata, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 5'd9 || mem_wdata !== 16'd2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL data_hi0: we=%b addr=%0d data=%h rdy=%b, expected 1 9 0002 1", mem_we, mem_addr, mem_wdata, in_ready);
        end
        send_word(32'hBEEF_0003, 1'b1);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 5'd10 || mem_wdata !== 16'd3) begin
            n_fail++;
            $display("FAIL data_lo1: we=%b addr=%0d data=%h, expected 1 10 0003", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL data_odd_tail: mwe=%b err=%b rdy=%b, expected 0 0 1", mem_we, err, in_ready);
        end
    endtask

    task automatic test_range_err();
        int writes;
        writes = 0;
        send_word(32'h204F_0000, 1'b0);
        n_checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL range_err: err=%b rdy=%b mwe=%b, expected 1 0 0", err, in_ready, mem_we);
        end
        repeat (3) begin
            @(negedge clk);
            if (mem_we || instr_we) writes++;
        end
        n_checks++;
        if (writes != 0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_hold: writes=%0d err=%b, expected 0 1", writes, err);
        end
        do_reset();
    endtask

    task automatic test_early_last();
        logic [31:0] d;
        int writes;
        d = $urandom;
        writes = 0;
        send_word(32'h1020_0000, 1'b0);
        send_word(d, 1'b1);
        n_checks++;
        if (instr_we !== 1'b1 || instr_addr !== 4'd0 || instr_wdata !== d) begin
            n_fail++;
            $display("FAIL early_last_wr: we=%b addr=%0d data=%h, expected 1 0 %h", instr_we, instr_addr, instr_wdata, d);
        end
        repeat (3) begin
            @(negedge clk);
            if (instr_we || mem_we) writes++;
        end
        n_checks++;
        if (writes != 0 || err !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_last_err: extra_writes=%0d err=%b rdy=%b, expected 0 1 0", writes, err, in_ready);
        end
        do_reset();
    endtask

    task automatic test_header_errors();
        send_word(32'h1000_0000, 1'b1);
        send_word(32'h2000_0000, 1'b1);
        n_checks++;
        if (err !== 1'b0 || in_ready !== 1'b1 || instr_we !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_count_noop: err=%b rdy=%b iwe=%b mwe=%b, expected 0 1 0 0", err, in_ready, instr_we, mem_we);
        end
        send_word(32'h2000_0000, 1'b0);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_count_nolast: err=%b, expected 1", err);
        end
        do_reset();
        send_word(32'h5000_0000, 1'b1);
        n_checks++;
        if (err !== 1'b1 || run !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_type: err=%b run=%b, expected 1 0", err, run);
        end
        do_reset();
    endtask

    task automatic test_start();
        int writes;
        writes = 0;
        send_word(32'h3000_0000, 1'b1);
        n_checks++;
        if (run !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_run: run=%b rdy=%b err=%b, expected 1 0 0", run, in_ready, err);
        end
        in_valid = 1'b1;
        in_data  = 32'h1011_0000;
        in_last  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (instr_we || mem_we) writes++;
        end
        in_data = 32'h1234_5678;
        in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (instr_we || mem_we) writes++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (writes != 0 || run !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ignores_input: writes=%0d run=%b err=%b, expected 0 1 0", writes, run, err);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        send_word(32'h2040_0000, 1'b0);
        send_word($urandom, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, instr_we, instr_addr, instr_wdata, mem_we, mem_addr, mem_wdata, run, err} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: rdy=%b iwe=%b mwe=%b ma=%h md=%h run=%b err=%b, expected all 0",
                     in_ready, instr_we, mem_we, mem_addr, mem_wdata, run, err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d = $urandom;
        send_word(32'h1012_8000, 1'b0);
        send_word(d, 1'b1);
        n_checks++;
        if (instr_we !== 1'b1 || instr_addr !== 4'd5 || instr_wdata !== d || err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_pkt: we=%b addr=%0d data=%h err=%b, expected 1 5 %h 0",
                     instr_we, instr_addr, instr_wdata, err, d);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c;
        a = $urandom; b = $urandom; c = $urandom;
        act_instr.delete();
        act_mem.delete();
        send_word(32'h1027_0000, 1'b0);
        send_word(a, 1'b0);
        send_word(b, 1'b1);
        send_word(32'h202F_0000, 1'b0);
        send_word(c, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (act_instr.size() != 2 || act_mem.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: instr=%0d mem=%0d, expected 2 2", act_instr.size(), act_mem.size());
        end else begin
            n_checks++;
            if (act_instr[0].addr != 14 || act_instr[0].data !== a || act_instr[1].addr != 15 || act_instr[1].data !== b) begin
                n_fail++;
                $display("FAIL b2b_instr: got %0d:%h %0d:%h, expected 14:%h 15:%h",
                         act_instr[0].addr, act_instr[0].data, act_instr[1].addr, act_instr[1].data, a, b);
            end
            n_checks++;
            if (act_mem[0].addr != 30 || act_mem[0].data !== {16'd0, c[15:0]} ||
                act_mem[1].addr != 31 || act_mem[1].data !== {16'd0, c[31:16]}) begin
                n_fail++;
                $display("FAIL b2b_mem: got %0d:%h %0d:%h, expected 30:%h 31:%h",
                         act_mem[0].addr, act_mem[0].data, act_mem[1].addr, act_mem[1].data, c[15:0], c[31:16]);
            end
        end
        n_checks++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_status: err=%b rdy=%b, expected 0 1", err, in_ready);
        end
    endtask

    task automatic test_random();
        int r, typ, base, cnt, depth, lim, nw, n_acc, fin;
        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(0, 19);
            if (r <= 8)       typ = 1;
            else if (r <= 17) typ = 2;
            else if (r == 18) typ = 3;
            else              typ = $urandom_range(4, 15);
            depth = (typ == 1) ? 16 : 32;
            nw = 1;
            if (typ == 1 || typ == 2) begin
                base = $urandom_range(0, depth - 1);
                lim  = depth - base;
                if (lim > 12) lim = 12;
                if ($urandom_range(0, 9) == 0) cnt = depth - base + $urandom_range(1, 4);
                else                           cnt = $urandom_range(0, lim);
                if (cnt > 0 && base + cnt <= depth) nw = 1 + ((typ == 1) ? cnt : (cnt + 1) / 2);
            end else begin
                base = $urandom_range(0, 31);
                cnt  = $urandom_range(0, 255);
            end
            pkt_data[0] = {4'(typ), 8'(cnt), 5'(base), 15'($urandom)};
            for (int k = 1; k < nw; k++) pkt_data[k] = $urandom;
            for (int k = 0; k < nw; k++) pkt_last[k] = (k == nw - 1);
            if ($urandom_range(0, 6) == 0) begin
                r = $urandom_range(0, nw - 1);
                pkt_last[r] = !pkt_last[r];
            end
            model_packet(nw, n_acc, fin);
            act_instr.delete();
            act_mem.delete();
            for (int k = 0; k < n_acc; k++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send_word(pkt_data[k], pkt_last[k]);
            end
            repeat (3) @(negedge clk);
            n_checks++;
            if (act_instr.size() != exp_instr.size() || act_mem.size() != exp_mem.size()) begin
                n_fail++;
                $display("FAIL rnd%0d write_counts: instr=%0d mem=%0d, expected %0d %0d (hdr=%h)",
                         p, act_instr.size(), act_mem.size(), exp_instr.size(), exp_mem.size(), pkt_data[0]);
            end else begin
                foreach (exp_instr[i]) begin
                    n_checks++;
                    if (act_instr[i].addr != exp_instr[i].addr || act_instr[i].data !== exp_instr[i].data) begin
                        n_fail++;
                        $display("FAIL rnd%0d instr_wr%0d: got %0d:%h, expected %0d:%h", p, i,
                                 act_instr[i].addr, act_instr[i].data, exp_instr[i].addr, exp_instr[i].data);
                    end
                end
                foreach (exp_mem[i]) begin
                    n_checks++;
                    if (act_mem[i].addr != exp_mem[i].addr || act_mem[i].data !== exp_mem[i].data) begin
                        n_fail++;
                        $display("FAIL rnd%0d mem_wr%0d: got %0d:%h, expected %0d:%h", p, i,
                                 act_mem[i].addr, act_mem[i].data, exp_mem[i].addr, exp_mem[i].data);
                    end
                end
            end
            n_checks++;
            if (err !== (fin == F_ERR) || run !== (fin == F_RUN) || in_ready !== (fin == F_IDLE)) begin
                n_fail++;
                $display("FAIL rnd%0d status: err=%b run=%b rdy=%b, expected %b %b %b (hdr=%h)", p, err, run, in_ready,
                         (fin == F_ERR), (fin == F_RUN), (fin == F_IDLE), pkt_data[0]);
            end
            if (fin != F_IDLE) do_reset();
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (both_hi !== 0) begin
            n_fail++;
            $display("FAIL strobe_exclusive: both strobes high in %0d cycles, expected 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_instr();
        test_data();
        test_range_err();
        test_early_last();
        test_header_errors();
        test_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter NUM_SIZE, default 16, data-memory word width.
REQ-002 Parameter NUM_INSTRUCTIONS, default 16, instruction-store depth (32-bit words).
REQ-003 Parameter WORDS_IN_MEMORY, default 32, data-memory depth.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  stream word valid.
REQ-007 in_ready  output  1  loader can accept a word.
REQ-008 in_data  input  32  header or payload word.
REQ-009 in_last  input  1  marks final word of a packet.
REQ-010 instr_we  output  1  instruction-store write strobe.
REQ-011 instr_addr  output  $clog2(NUM_INSTRUCTIONS)  instruction write address.
REQ-012 instr_wdata  output  32  instruction write data.
REQ-013 mem_we  output  1  data-memory write strobe.
REQ-014 mem_addr  output  $clog2(WORDS_IN_MEMORY)  data write address.
REQ-015 mem_wdata  output  NUM_SIZE  data write data.
REQ-016 run  output  1  enable released to the accelerator core.
REQ-017 err  output  1  sticky protocol error.

Function
REQ-018 Word transfer occurs on a rising edge with in_valid && in_ready.
REQ-019 Header fields: [31:28] type, [27:20] count, [19:15] base; type 1 = INSTR, 2 = DATA, 3 = START; all other types are errors.
REQ-020 FSM states: IDLE (awaiting header), INSTR, DATA_LO, DATA_HI, RUN, ERR.
REQ-021 in_ready = 1 in IDLE, INSTR and DATA_LO; 0 in DATA_HI, RUN and ERR.
REQ-022 INSTR: payload word i SHALL produce instr_we=1, instr_addr=base+i, instr_wdata=word on the cycle after acceptance (registered, latency 1).
REQ-023 DATA: count = number of 16-bit values, packed two per payload word with the low half first; an accepted word writes the low half to base+2j on the next cycle.
REQ-024 If a second value remains, the FSM enters DATA_HI for exactly one cycle, writing the high half to base+2j+1; for an odd count, the high half of the final word is ignored.
REQ-025 Range check at header: if base+count > depth (computed without wrap), go to ERR with no writes.
REQ-026 A header with count 0 of type 1 or 2 is a no-op and requires in_last=1 on the header.
REQ-027 in_last SHALL be 1 exactly on the final word of a packet; early or missing in_last leads to ERR, and writes already issued stand.
REQ-028 START accepted with in_last=1: run = 1 from the next cycle, state RUN, held until rst.
REQ-029 ERR: err=1, run=0, no strobes; state held until rst.
REQ-030 instr_we and mem_we SHALL never be high in the same cycle; strobes are single-cycle.

Reset
REQ-031 On rst: state IDLE; in_ready, strobes, addresses, write data, run and err all 0.
REQ-032 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-033 Reset mid-packet abandons the packet; the loader does not clear target memories.

Structure
REQ-034 Package accel_pkg SHALL hold NUM_SIZE, NUM_INSTRUCTIONS, WORDS_IN_MEMORY, header field positions, type codes and the FSM state enum.
REQ-035 The block is a single module with no sub-module; header decode is inline.

Verification
REQ-036 Header 0x10310000 (INSTR, count 3, base 2), then payloads A, B, C (last on C) -> instr_we at addresses 2, 3, 4 with data A, B, C; err=0.
REQ-037 Header 0x20340000 (DATA, count 3, base 8), then payloads 0x00020001 and 0x00000003 (last) -> memory 8=1, 9=2, 10=3; in_ready low for one cycle after the first payload.
REQ-038 Header 0x204F0000 (DATA, count 4, base 30) -> err=1 on the next cycle, no mem_we, in_ready=0.
REQ-039 INSTR count 2 with in_last on the first payload -> exactly one instr write, then err=1.
REQ-040 Header 0x30000000 with in_last -> run=1 on the next cycle, in_ready=0, and later in_valid has no effect.
REQ-041 rst asserted mid-DATA packet -> all outputs 0 immediately; a fresh header after release is processed normally.
